// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver (LSB first) pushing good bytes into a show-ahead FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit between D7 and the stop bit.
module uart_rx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     uartrx,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rx_busy,
  output logic                     frame_err,
  output logic                     overflow
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP, WAIT_IDLE
  } state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic rxs, wrap, push, ferr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
`ifdef UART_RX_PARITY_EN
  logic bad, bad_n;
`endif
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_rd, do_wr;
  assign rxs = sync[1];
  assign wrap = cnt == LAST;
  assign rx_busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= 2'b11;
    else sync <= {sync[0], uartrx};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bad <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      bad <= bad_n;
`endif
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    sh_n = sh;
    push = 1'b0;
    ferr_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_n = bad;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rxs ? IDLE : START;
      end
      START:
        if (cnt == HALF) begin
          cnt_n = '0;
          idx_n = '0;
          sh_n = '0;
          state_n = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
          bad_n = 1'b0;
`endif
        end else cnt_n = cnt + CW'(1);
      DATA:
        if (wrap) begin
          cnt_n = '0;
          sh_n = {rxs, sh[7:1]};
          idx_n = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx == 3'd7) state_n = PARITY;
`else
          if (idx == 3'd7) state_n = STOP;
`endif
        end else cnt_n = cnt + CW'(1);
`ifdef UART_RX_PARITY_EN
      PARITY:
        if (wrap) begin
          cnt_n = '0;
          state_n = STOP;
          ferr_n = ^{sh, rxs};
          bad_n = ^{sh, rxs};
        end else cnt_n = cnt + CW'(1);
`endif
      STOP:
        if (wrap) begin
          cnt_n = '0;
`ifdef UART_RX_PARITY_EN
          push = rxs && !bad;
`else
          push = rxs;
`endif
          ferr_n = !rxs;
          state_n = rxs ? IDLE : WAIT_IDLE;
        end else cnt_n = cnt + CW'(1);
      WAIT_IDLE: state_n = rxs ? IDLE : WAIT_IDLE;
      default: state_n = IDLE;
    endcase
  end
  // A pop frees the slot a same-cycle push needs, so push-while-full succeeds only with a read.
  assign count = wr_ptr - rd_ptr;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_rd = rd_en && !empty;
  assign do_wr = push && (!full || do_rd);
  assign rd_data = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr[AW-1:0]] <= sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= do_wr ? wr_ptr + (AW+1)'(1) : wr_ptr;
      rd_ptr <= do_rd ? rd_ptr + (AW+1)'(1) : rd_ptr;
      overflow <= push && !do_wr;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed tests of uart_rx_fifo at CLK_PER_BIT=16, DEPTH=4.
module tb_uart_rx_fifo;
  localparam int CPB = 16;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0, uartrx = 1'b1, rd_en = 1'b0;
  logic [7:0] rd_data;
  logic empty, full, rx_busy, frame_err, overflow;
  logic [2:0] count;
  int checks = 0, failures = 0, ferr_cnt = 0, ovf_cnt = 0;

  uart_rx_fifo #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .uartrx(uartrx), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .rx_busy(rx_busy),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    uartrx = v;
    cyc(CPB);
  endtask

  // Stop bit sampled 12 cycles into its period; pop_at_push raises rd_en on exactly that edge.
  task automatic send(input logic [7:0] b, input logic stop, input int hold, input logic pop_at_push);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    uartrx = stop;
    if (pop_at_push) begin
      cyc(11);
      rd_en = 1'b1;
      cyc(1);
      rd_en = 1'b0;
      cyc(CPB - 12);
    end else cyc(CPB);
    cyc(hold);
    uartrx = 1'b1;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_rx_busy got=%b exp=0", rx_busy); end
    checks++; if (frame_err !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", frame_err, overflow); end
    rst_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_basic();
    send(8'h55, 1'b1, 0, 1'b0);
    send(8'hA3, 1'b1, 0, 1'b0);
    cyc(2);
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL basic_count2 got=%0d exp=2", count); end
    checks++; if (rd_data !== 8'h55) begin failures++; $display("FAIL basic_head got=%h exp=55", rd_data); end
    pop();
    checks++; if (rd_data !== 8'hA3) begin failures++; $display("FAIL basic_second got=%h exp=a3", rd_data); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL basic_count1 got=%0d exp=1", count); end
    pop();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", empty); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL basic_rd_zero got=%h exp=00", rd_data); end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = ferr_cnt;
    uartrx = 1'b0;
    cyc(4);
    checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_high got=%b exp=1", rx_busy); end
    uartrx = 1'b1;
    cyc(10);
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_low got=%b exp=0", rx_busy); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL glitch_count got=%0d exp=0", count); end
    checks++; if (ferr_cnt !== f0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=%0d", ferr_cnt, f0); end
  endtask

  task automatic test_framing();
    int f0;
    f0 = ferr_cnt;
    send(8'h3C, 1'b0, 40, 1'b0);
    cyc(20);
    checks++; if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL frame_err_pulses got=%0d exp=%0d", ferr_cnt - f0, 1); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL frame_count got=%0d exp=0", count); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL frame_busy got=%b exp=0", rx_busy); end
    send(8'h7E, 1'b1, 0, 1'b0);
    cyc(2);
    checks++; if (count !== 3'd1 || rd_data !== 8'h7E) begin failures++; $display("FAIL frame_recover got=%0d/%h exp=1/7e", count, rd_data); end
    checks++; if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL frame_err_after got=%0d exp=%0d", ferr_cnt - f0, 1); end
    pop();
  endtask

  task automatic test_overflow();
    int o0;
    o0 = ovf_cnt;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 0, 1'b0);
    cyc(2);
    checks++; if (full !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL ovf_full got=%b/%0d exp=1/4", full, count); end
    checks++; if (ovf_cnt !== o0) begin failures++; $display("FAIL ovf_early got=%0d exp=0", ovf_cnt - o0); end
    send(8'h05, 1'b1, 0, 1'b0);
    cyc(2);
    checks++; if (ovf_cnt !== o0 + 1) begin failures++; $display("FAIL ovf_pulse got=%0d exp=1", ovf_cnt - o0); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (rd_data !== 8'(i)) begin failures++; $display("FAIL ovf_drain got=%h exp=%h", rd_data, 8'(i)); end
      pop();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b exp=1", empty); end
  endtask

  task automatic test_simul();
    int o0;
    logic [7:0] exp_q [4];
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h99};
    o0 = ovf_cnt;
    send(8'h11, 1'b1, 0, 1'b0);
    send(8'h22, 1'b1, 0, 1'b0);
    send(8'h33, 1'b1, 0, 1'b0);
    send(8'h44, 1'b1, 0, 1'b0);
    send(8'h99, 1'b1, 0, 1'b1);
    cyc(2);
    checks++; if (ovf_cnt !== o0) begin failures++; $display("FAIL simul_ovf got=%0d exp=0", ovf_cnt - o0); end
    checks++; if (count !== 3'd4 || full !== 1'b1) begin failures++; $display("FAIL simul_count got=%0d/%b exp=4/1", count, full); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data !== exp_q[i]) begin failures++; $display("FAIL simul_order got=%h exp=%h", rd_data, exp_q[i]); end
      pop();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL simul_empty got=%b exp=1", empty); end
  endtask

  task automatic test_mid_reset();
    send(8'h5A, 1'b1, 0, 1'b0);
    uartrx = 1'b0;
    cyc(40);
    checks++; if (rx_busy !== 1'b1 || count !== 3'd1) begin failures++; $display("FAIL midrst_pre got=%b/%0d exp=1/1", rx_busy, count); end
    rst_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1 || rx_busy !== 1'b0 || rd_data !== 8'h00) begin failures++; $display("FAIL midrst_async got=%b/%b/%h exp=1/0/00", empty, rx_busy, rd_data); end
    uartrx = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(CPB * 10);
    checks++; if (count !== 3'd0 || rx_busy !== 1'b0) begin failures++; $display("FAIL midrst_post got=%0d/%b exp=0/0", count, rx_busy); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int f0;
    f0 = ferr_cnt;
    send(8'h07, 1'b1, 0, 1'b0);
    cyc(2);
    checks++; if (count !== 3'd1 || rd_data !== 8'h07) begin failures++; $display("FAIL par_good got=%0d/%h exp=1/07", count, rd_data); end
    pop();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i < 3);
    drive_bit(1'b0);
    drive_bit(1'b1);
    cyc(4);
    checks++; if (ferr_cnt !== f0 + 1) begin failures++; $display("FAIL par_ferr got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL par_bad_count got=%0d exp=0", count); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overflow();
    test_simul();
    test_mid_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Buffered UART receiver: the receive-side counterpart of the buffered transmitter. Deserialises 8N1 frames (LSB first) from the board RX pin and pushes each good byte into an internal FIFO. Consumers drain the FIFO with a show-ahead read handshake. Framing errors and overflow are reported as single-cycle pulses.

## Interface
- `CLK_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200). Minimum 8.
- `DEPTH`, default 16: number of FIFO entries. Must be a power of two, at least 2.
- `clk` input, 1: single clock; all logic on the rising edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `uartrx` input, 1: serial line; idles high; asynchronous to `clk`.
- `rd_en` input, 1: pop request; ignored while `empty`=1.
- `rd_data` output, 8: head of FIFO (show-ahead); 0 while `empty`.
- `empty` output, 1: FIFO holds no bytes.
- `full` output, 1: FIFO holds `DEPTH` bytes.
- `count` output, $clog2(DEPTH)+1: number of bytes stored.
- `rx_busy` output, 1: high whenever the FSM is not in IDLE.
- `frame_err` output, 1: one-cycle pulse when a frame is rejected.
- `overflow` output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Synchroniser.** `uartrx` passes through 2 flops that reset to 1. The FSM sees only the synchronised value `rxs`.
- **Bit timer.** Counter width is $clog2(CLK_PER_BIT). The half point is `CLK_PER_BIT/2`, integer division.
- **IDLE.** Counter held at 0. Go to START when `rxs`=0.
- **START.** Count to `CLK_PER_BIT/2`.
  - If `rxs`=1 at that point, the start was a glitch: return to IDLE with no error.
  - Otherwise clear the counter, set bit index to 0, clear the shift register, go to DATA.
- **DATA.** Every `CLK_PER_BIT` cycles (counter wraps from `CLK_PER_BIT-1` to 0), sample `rxs` at mid-bit.
  - Shift the sample in from the MSB side, so LSB-first order is preserved.
  - After bit index 7, go to STOP (or PARITY when configured).
- **STOP.** After `CLK_PER_BIT` cycles, sample `rxs`.
  - 1: the byte is good. Push it and go to IDLE.
  - 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
- **WAIT_IDLE.** Stay until `rxs`=1, then go to IDLE. This prevents a break condition (line held low) from being read as repeated start bits.
- **FIFO.**
  - Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty.
  - Storage is not reset.
  - A push while full and `rd_en`=0 drops the byte and pulses `overflow`; no pointer changes.
  - Push while full together with `rd_en`=1: both the pop and the push happen; `count` stays at `DEPTH`; no overflow.
  - Push while empty together with `rd_en`=1: the pop is ignored because `empty` is 1; the byte is stored.
  - Pointers wrap modulo 2·`DEPTH`.

## Timing
- **Reset values.** `empty`=1, `full`=0, `count`=0, `rd_data`=0, `rx_busy`=0, `frame_err`=0, `overflow`=0. FSM in IDLE, synchroniser = 1.
- **Mid-operation reset.** Asserting `rst_n` low aborts any frame immediately and empties the FIFO. The partial byte is lost.
- **Input latency.** 2 cycles from a `uartrx` edge to `rxs`.
- **Push latency.** The stop-bit sample cycle registers the push. `empty` falls and `count` increments on the next edge.
- **Frame length.** From the `rxs` falling edge to push: `CLK_PER_BIT/2` + 9·`CLK_PER_BIT` cycles (+1·`CLK_PER_BIT` with parity).
- **Read handshake.**
  - `rd_data` is valid combinationally whenever `empty`=0.
  - `rd_en` sampled high pops on that edge; the next entry appears after the edge.
  - Back-to-back pops every cycle are allowed.
- **Pulses.** `frame_err` and `overflow` are registered, high for exactly one cycle.
- **Back-to-back frames.** Accepted: from IDLE after a good stop-bit sample, a new start edge is detected with no gap cycle.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- **Defined:** an even-parity bit is expected between D7 and the stop bit, handled in a PARITY state sampled at mid-bit. A parity mismatch pulses `frame_err` and discards the byte; the FSM then proceeds to STOP, and a parity-fail frame with a good stop goes to IDLE.
- **Undefined:** the PARITY state and its logic are absent. The frame is 8N1.

## Test plan
1. **Reset.** `CLK_PER_BIT`=16, `DEPTH`=4. Send 0x55 then 0xA3 with `rd_en`=0. Required: `count`=2 and `rd_data`=0x55. Pulse `rd_en` once: `rd_data`=0xA3, `count`=1. Pulse again: `empty`=1, `rd_data`=0.
2. **Glitch.** Drive `uartrx` low for 4 cycles, then high. Required: no push, no `frame_err`; `rx_busy` returns low within 8+2 cycles.
3. **Framing.** Send 0x3C with stop bit = 0, and hold the line low 40 cycles. Required: exactly one `frame_err` pulse, `count` unchanged, no false frame during the low hold. A following good 0x7E is stored.
4. **Overflow.** `DEPTH`=4. Send 0x01–0x05 with no reads. Required: `full`=1 after 0x04, one `overflow` pulse on 0x05. Draining yields 0x01–0x04.
5. **Simultaneous push/pop.** Fill to `DEPTH`=4, then assert `rd_en` on the push cycle of 0x99. Required: no overflow, `count`=4, 0x99 read last.
6. **Parity** (`UART_RX_PARITY_EN`). Send 0x07 with parity bit 1: stored. Send 0x07 with parity bit 0: `frame_err` pulse, not stored.
